// File: rtl/binary_to_gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : binary_to_gray_counter_if
//  Brief    : Control and result bundle for binary_to_gray_counter.
//             The master side drives enable/load/direction, the slave side
//             (the counter) returns the binary/Gray codes and status pulses.
//             i_dir is present only when GRAY_DOWN_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface binary_to_gray_counter_if #(
  parameter int WIDTH = 4
);

  logic             i_en;
  logic             i_load;
  logic [WIDTH-1:0] i_load_bin;
`ifdef GRAY_DOWN_EN
  logic             i_dir;
`endif
  logic [WIDTH-1:0] o_binary;
  logic [WIDTH-1:0] o_gray;
  logic             o_valid;
  logic             o_wrap;

  // Stimulus side: drives the control strobes, observes the codes.
  modport master (
`ifdef GRAY_DOWN_EN
    output i_dir,
`endif
    output i_en,
    output i_load,
    output i_load_bin,
    input  o_binary,
    input  o_gray,
    input  o_valid,
    input  o_wrap
  );

  // Counter side: consumes the control strobes, produces the codes.
  modport slave (
`ifdef GRAY_DOWN_EN
    input  i_dir,
`endif
    input  i_en,
    input  i_load,
    input  i_load_bin,
    output o_binary,
    output o_gray,
    output o_valid,
    output o_wrap
  );

endinterface : binary_to_gray_counter_if
`default_nettype wire

// File: rtl/binary_to_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : binary_to_gray_counter
//  Brief    : Loadable binary counter with a registered Gray-code copy.
//             Both codes are updated on the same edge so they never disagree.
//             o_valid pulses after each load or count step, o_wrap after a
//             count step that rolls over. Loads never raise o_wrap.
//             Macro GRAY_DOWN_EN adds i_dir (0 = up, 1 = down); without it
//             the counter counts up only.
//  Revision : 1.0 - initial release
// ============================================================================
module binary_to_gray_counter #(
  parameter int WIDTH = 4   // must match the WIDTH of the connected interface
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst,
  binary_to_gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q,  wrap_d;
  logic             w_down;

  // Direction select: fixed to up when the down-count feature is absent.
`ifdef GRAY_DOWN_EN
  assign w_down = bus.i_dir;
`else
  assign w_down = 1'b0;
`endif

  // Next-state: load beats count beats hold; Gray derived from the new binary
  // value so the registered pair is always consistent.
  always_comb begin
    bin_d   = bin_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.i_load) begin
      bin_d   = bus.i_load_bin;
      valid_d = 1'b1;
    end else if (bus.i_en) begin
      valid_d = 1'b1;
      if (w_down) begin
        bin_d  = bin_q - c_ONE;
        wrap_d = ~|bin_q;
      end else begin
        bin_d  = bin_q + c_ONE;
        wrap_d = &bin_q;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State register with asynchronous clear of codes and status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o_binary = bin_q;
  assign bus.o_gray   = gray_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_wrap   = wrap_q;

endmodule : binary_to_gray_counter
`default_nettype wire

// File: tb/tb_binary_to_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_to_gray_counter
//  Brief    : Self-checking bench for binary_to_gray_counter (WIDTH = 4).
//             Table of {inputs, expected outputs} records applied in a loop,
//             plus hand-written reset and direction sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_binary_to_gray_counter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  binary_to_gray_counter_if #(.WIDTH(WIDTH)) bus ();

  binary_to_gray_counter #(.WIDTH(WIDTH)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic       dir;
    logic [3:0] lb;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       valid;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       valid;
    logic       wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  function automatic vec_t mk(logic ld, logic en, logic dir, logic [3:0] lb,
                              logic [3:0] b, logic [3:0] g, logic v, logic w);
    vec_t r;
    r.load = ld; r.en = en; r.dir = dir; r.lb = lb;
    r.bin = b; r.gray = g; r.valid = v; r.wrap = w;
    return r;
  endfunction

  task automatic push_exp(logic [3:0] b, logic [3:0] g, logic v, logic w);
    exp_t e;
    e.bin = b; e.gray = g; e.valid = v; e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, no expected value queued", tag);
      return;
    end
    e = exp_q.pop_front();
    vectors_applied++;
    if (bus.o_binary !== e.bin || bus.o_gray !== e.gray ||
        bus.o_valid !== e.valid || bus.o_wrap !== e.wrap) begin
      miscompares++;
      $display("FAIL %s: got bin=%b gray=%b valid=%b wrap=%b, want bin=%b gray=%b valid=%b wrap=%b",
               tag, bus.o_binary, bus.o_gray, bus.o_valid, bus.o_wrap,
               e.bin, e.gray, e.valid, e.wrap);
    end
  endtask

  // Drive one record, queue its expectation, check 1 time unit after the edge.
  task automatic apply(input vec_t v, input string tag);
    bus.i_load     = v.load;
    bus.i_en       = v.en;
    bus.i_load_bin = v.lb;
`ifdef GRAY_DOWN_EN
    bus.i_dir      = v.dir;
`endif
    push_exp(v.bin, v.gray, v.valid, v.wrap);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic idle_inputs();
    bus.i_load     = 1'b0;
    bus.i_en       = 1'b0;
    bus.i_load_bin = 4'b0000;
`ifdef GRAY_DOWN_EN
    bus.i_dir      = 1'b0;
`endif
  endtask

  // Reset with clock running; release just after an edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b0);
    compare_out("reset_state");
    rst = 1'b0;
  endtask

  // Assert reset between edges and check outputs clear before the next edge.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b0);
    compare_out(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0] gseq [16];
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    rst = 1'b1;
    idle_inputs();
    #1;
    // Async clear visible before any clock edge.
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b0);
    compare_out("reset_no_clock");
    do_reset();

    // Full up-count: 16 steps, wrap only on the return to zero.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'((i + 1) % 16), gseq[i], 1'b1, (i == 15)));
    // Load all-ones then hold three cycles.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0));
    // Plain load.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1011, 4'b1011, 4'b1110, 1'b1, 1'b0));
    // Load wins over enable on the same edge.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0101, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111, 4'b0100, 1'b1, 1'b0));
    // Loading zero never wraps.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    // Load all-ones then step: wrap pulse, then no wrap on the next step.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0));
    // Loading all-ones with enable high never wraps.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Count to 0101, reset between edges, resume from 0001.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 5; i++)
      apply(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'(i + 1), gseq[i], 1'b1, 1'b0), "count_to_5");
    idle_inputs();
    mid_cycle_reset("reset_mid_count");
    apply(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0), "resume_after_reset");

    // A wrap pulse does not survive reset.
    apply(mk(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0), "load_f_pre_wrap");
    apply(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1), "wrap_pre_reset");
    idle_inputs();
    mid_cycle_reset("reset_kills_wrap");
    apply(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0), "hold_after_reset");

`ifdef GRAY_DOWN_EN
    // Down-count from zero wraps to all-ones, then steps down normally.
    do_reset();
    apply(mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b1), "down_wrap");
    apply(mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1110, 4'b1001, 1'b1, 1'b0), "down_step");
    // Direction change applies on the next step.
    apply(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0), "dir_flip_up");
    apply(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1), "up_wrap_after_flip");
`endif

    idle_inputs();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule : tb_binary_to_gray_counter
`default_nettype wire

// File: doc/binary_to_gray_counter.md
BINARY_TO_GRAY_COUNTER -- requirements
Module: binary_to_gray_counter

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, bit width of the counter and of both code outputs (legal range 2..16).
REQ-002 Port i_clk SHALL be: i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port i_rst SHALL be: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port i_en SHALL be: i_en  input  1  count enable; one count step per cycle while high.
REQ-005 Port i_load SHALL be: i_load  input  1  synchronous load strobe.
REQ-006 Port i_load_bin SHALL be: i_load_bin  input  WIDTH  binary value captured on load.
REQ-007 Port i_dir SHALL be: i_dir  input  1  count direction, 0 = up, 1 = down (present only with GRAY_DOWN_EN, see REQ-024).
REQ-008 Port o_binary SHALL be: o_binary  output  WIDTH  registered binary count.
REQ-009 Port o_gray SHALL be: o_gray  output  WIDTH  registered Gray encoding of o_binary.
REQ-010 Port o_valid SHALL be: o_valid  output  1  one-cycle pulse after each load or count step.
REQ-011 Port o_wrap SHALL be: o_wrap  output  1  one-cycle pulse after a count step that wraps.

Function
REQ-012 Priority SHALL be: reset > i_load > i_en > hold.
REQ-013 On i_load high at a rising edge, o_binary SHALL take i_load_bin and o_gray SHALL take i_load_bin ^ (i_load_bin >> 1), both visible after that edge (latency 1), regardless of i_en.
REQ-014 On i_en high with i_load low, o_binary SHALL take (o_binary + 1) mod 2^WIDTH (up) or (o_binary - 1) mod 2^WIDTH (down), and o_gray SHALL take the Gray encoding of that new binary value in the same edge.
REQ-015 o_gray SHALL always equal o_binary ^ (o_binary >> 1); no cycle may show a mismatched pair.
REQ-016 Each count step SHALL change exactly one bit of o_gray, including the wrap step.
REQ-017 With i_en and i_load both low, o_binary and o_gray SHALL hold, and o_valid and o_wrap SHALL be 0.
REQ-018 o_valid SHALL be 1 for exactly the cycle following any edge on which a load or count step occurred; back-to-back steps keep it high continuously.
REQ-019 o_wrap SHALL pulse for one cycle after an up step from all-ones to zero or a down step from zero to all-ones; a load SHALL never set o_wrap, even when loading zero or all-ones.

Reset
REQ-020 Asserting i_rst SHALL immediately, without waiting for a clock edge, force o_binary, o_gray, o_valid and o_wrap to 0.
REQ-021 Reset asserted mid-count SHALL discard the in-progress value; no wrap or valid pulse SHALL survive reset.
REQ-022 On the first rising edge after i_rst deasserts, normal priority (REQ-012) SHALL apply.

Configuration
REQ-023 Macro GRAY_DOWN_EN SHALL control the down-count feature.
REQ-024 With GRAY_DOWN_EN defined, port i_dir SHALL exist and select direction per REQ-007; a direction change takes effect on the next count step.
REQ-025 Without GRAY_DOWN_EN, port i_dir SHALL be absent and the counter SHALL count up only; all other behaviour is unchanged.

Verification (WIDTH = 4)
REQ-026 Reset, then i_en = 1 for 16 cycles -> o_gray sequence is 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; o_wrap = 1 only in the cycle o_gray returns to 0000; o_valid = 1 throughout.
REQ-027 i_load = 1 with i_load_bin = 1011 -> next cycle o_binary = 1011, o_gray = 1110, o_valid = 1, o_wrap = 0.
REQ-028 i_load = 1 with i_load_bin = 0110 and i_en = 1 on the same edge -> o_binary = 0110, o_gray = 0101, and no increment that cycle.
REQ-029 Count to o_binary = 0101, then pulse i_rst between clock edges -> all outputs become 0 before the next edge; counting resumes from 0001 after release.
REQ-030 With GRAY_DOWN_EN: from reset, i_dir = 1 and i_en = 1 -> o_binary = 1111, o_gray = 1000, o_wrap = 1; next step -> 1110/1001, o_wrap = 0.
REQ-031 Load 1111 (with i_load_bin = 1111), then i_en = 0 for 3 cycles -> o_gray holds 1000; o_valid = 0 and o_wrap = 0 during the hold cycles.
